led_seq_ctrl: RTL and testbench

- AHB-lite-programmable LED pattern sequencer. Replaces the free-running LED blinker inside analog_ip with a CPU-configured controller.
- Firmware writes a step table, where each step has an LED mask and a duration, plus a prescaler, then sets EN.
- The block plays the table once or in a loop, and raises an interrupt on completion.
- Sits on the mem_ahb slave port of analog_ip; led drives LED_D2/LED_D3; irq drives local_int[0].

---
 rtl/led_seq_pkg.sv | 41 ++++
 rtl/led_seq_regs.sv | 144 ++++++++++++++
 rtl/led_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, bit positions,
// FSM state encoding and the clamping helpers used by the sequencer.
package led_seq_pkg;

  localparam logic [7:0] OFS_CTRL      = 8'h00;
  localparam logic [7:0] OFS_PRESC     = 8'h04;
  localparam logic [7:0] OFS_NSTEPS    = 8'h08;
  localparam logic [7:0] OFS_STATUS    = 8'h0C;
  localparam logic [7:0] OFS_STEP_BASE = 8'h40;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_LOOP     = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_STEP_LSB = 8;

  localparam int unsigned DUR_LSB       = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

  // A zero step count plays one step; anything past the table plays the whole table.
  function automatic logic [4:0] clamp_nsteps(input logic [4:0] n, input int unsigned depth);
    if (n == 5'd0)
      return 5'd1;
    else if (n > 5'(depth))
      return 5'(depth);
    else
      return n;
  endfunction

  function automatic logic [15:0] clamp_dur(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/led_seq_regs.sv
// AHB-lite slave, control/status registers and step table for the LED sequencer.
// Zero wait state: the address phase is registered, writes commit at the end of the data phase.
module led_seq_regs
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PRESC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               htrans,
  input  logic                     hready,
  input  logic                     hwrite,
  input  logic [31:0]              haddr,
  input  logic [31:0]              hwdata,
  output logic [31:0]              hrdata,
  output logic                     en,
  output logic                     loop,
  output logic [PRESC_W-1:0]       presc,
  output logic [4:0]               nsteps,
  output logic                     start,
  output logic                     irq,
  input  logic [$clog2(DEPTH)-1:0] step_idx,
  output logic [NUM_LEDS-1:0]      step_mask,
  output logic [15:0]              step_dur,
  input  logic                     busy,
  input  logic                     done_set
);

  localparam int unsigned SW = $clog2(DEPTH);

  logic                dp_valid;
  logic                dp_write;
  logic [5:0]          dp_waddr;
  logic                irq_en;
  logic                done;
  logic [NUM_LEDS-1:0] mask_tbl [DEPTH];
  logic [15:0]         dur_tbl  [DEPTH];

  logic                wr;
  logic                wr_ctrl;
  logic                wr_presc;
  logic                wr_nsteps;
  logic                wr_status;
  logic                wr_step;
  logic                is_step;
  logic [SW-1:0]       tbl_idx;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign unused_bits = &{1'b0, htrans[0], haddr[31:8], haddr[1:0], hwdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_waddr <= '0;
    end else if (hready) begin
      dp_valid <= htrans[1];
      dp_write <= hwrite;
      dp_waddr <= haddr[7:2];
    end
  end

  always_comb begin
    tbl_idx   = dp_waddr[SW-1:0];
    is_step   = (dp_waddr[5:4] == OFS_STEP_BASE[7:6]) && ({2'b00, dp_waddr[3:0]} < 6'(DEPTH));
    wr        = dp_valid && dp_write && hready;
    wr_ctrl   = wr && (dp_waddr == OFS_CTRL[7:2]);
    wr_presc  = wr && (dp_waddr == OFS_PRESC[7:2]);
    wr_nsteps = wr && (dp_waddr == OFS_NSTEPS[7:2]);
    wr_status = wr && (dp_waddr == OFS_STATUS[7:2]);
    wr_step   = wr && is_step;
  end

  always_comb begin
    rdata = '0;
    if (is_step) begin
      rdata[NUM_LEDS-1:0]   = mask_tbl[tbl_idx];
      rdata[DUR_LSB +: 16]  = dur_tbl[tbl_idx];
    end else begin
      case (dp_waddr)
        OFS_CTRL[7:2]: begin
          rdata[CTRL_EN]     = en;
          rdata[CTRL_LOOP]   = loop;
          rdata[CTRL_IRQ_EN] = irq_en;
        end
        OFS_PRESC[7:2]:  rdata[PRESC_W-1:0] = presc;
        OFS_NSTEPS[7:2]: rdata[4:0] = nsteps;
        OFS_STATUS[7:2]: begin
          rdata[STAT_BUSY]          = busy;
          rdata[STAT_DONE]          = done;
          rdata[STAT_STEP_LSB +: 4] = 4'(step_idx);
        end
        default: ;
      endcase
    end
  end

  assign hrdata    = (dp_valid && !dp_write) ? rdata : '0;
  assign step_mask = mask_tbl[step_idx];
  assign step_dur  = dur_tbl[step_idx];
  assign irq       = done & irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en     <= 1'b0;
      loop   <= 1'b0;
      irq_en <= 1'b0;
      presc  <= '0;
      nsteps <= '0;
      done   <= 1'b0;
      start  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mask_tbl[SW'(i)] <= '0;
        dur_tbl[SW'(i)]  <= '0;
      end
    end else begin
      // Registered start delays LOAD by one edge so the first mask lands two edges after the write.
      start <= wr_ctrl & hwdata[CTRL_EN];
      if (wr_ctrl) begin
        en     <= hwdata[CTRL_EN];
        loop   <= hwdata[CTRL_LOOP];
        irq_en <= hwdata[CTRL_IRQ_EN];
      end else if (done_set) begin
        en <= 1'b0;
      end
      if (wr_presc)
        presc <= hwdata[PRESC_W-1:0];
      if (wr_nsteps)
        nsteps <= hwdata[4:0];
      if (done_set)
        done <= 1'b1;
      else if (wr_status && hwdata[STAT_DONE])
        done <= 1'b0;
      if (wr_step) begin
        mask_tbl[tbl_idx] <= hwdata[NUM_LEDS-1:0];
        dur_tbl[tbl_idx]  <= hwdata[DUR_LSB +: 16];
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// AHB-lite programmable LED pattern sequencer: plays the step table once or in a loop
// and raises a level interrupt on completion.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PRESC_W  = 24
) (
  input  logic                sys_clock,
  input  logic                resetn,
  input  logic [1:0]          mem_ahb_htrans,
  input  logic                mem_ahb_hready,
  input  logic                mem_ahb_hwrite,
  input  logic [31:0]         mem_ahb_haddr,
  input  logic [31:0]         mem_ahb_hwdata,
  output logic                mem_ahb_hreadyout,
  output logic                mem_ahb_hresp,
  output logic [31:0]         mem_ahb_hrdata,
  output logic [NUM_LEDS-1:0] led,
  output logic                irq
);

  localparam int unsigned SW = $clog2(DEPTH);

  state_t              state;
  state_t              state_nx;
  logic [SW-1:0]       step;
  logic [SW-1:0]       step_nx;
  logic [15:0]         dur_cnt;
  logic [PRESC_W-1:0]  presc_cnt;
  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] led_nx;

  logic                en;
  logic                loop;
  logic                start;
  logic                done_set;
  logic                busy;
  logic                tick;
  logic                step_end;
  logic                last_step;
  logic [PRESC_W-1:0]  presc;
  logic [4:0]          nsteps;
  logic [NUM_LEDS-1:0] step_mask;
  logic [15:0]         step_dur;

  assign mem_ahb_hreadyout = 1'b1;
  assign mem_ahb_hresp     = 1'b0;
  assign led               = led_q;

  led_seq_regs #(
    .NUM_LEDS (NUM_LEDS),
    .DEPTH    (DEPTH),
    .PRESC_W  (PRESC_W)
  ) u_regs (
    .clk       (sys_clock),
    .rst_n     (resetn),
    .htrans    (mem_ahb_htrans),
    .hready    (mem_ahb_hready),
    .hwrite    (mem_ahb_hwrite),
    .haddr     (mem_ahb_haddr),
    .hwdata    (mem_ahb_hwdata),
    .hrdata    (mem_ahb_hrdata),
    .en        (en),
    .loop      (loop),
    .presc     (presc),
    .nsteps    (nsteps),
    .start     (start),
    .irq       (irq),
    .step_idx  (step),
    .step_mask (step_mask),
    .step_dur  (step_dur),
    .busy      (busy),
    .done_set  (done_set)
  );

  // >= rather than == so a PRESC lowered mid-step below the running count still ticks at once.
  always_comb begin
    tick      = (state == HOLD) && (presc_cnt >= presc);
    step_end  = tick && (dur_cnt <= 16'd1);
    last_step = (5'(step) + 5'd1) >= clamp_nsteps(nsteps, DEPTH);
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step;
    done_set = 1'b0;
    if (start) begin
      state_nx = LOAD;
      step_nx  = '0;
    end else if (!en) begin
      state_nx = IDLE;
      step_nx  = '0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: state_nx = HOLD;
        HOLD: begin
          if (step_end) begin
            if (!last_step) begin
              state_nx = LOAD;
              step_nx  = step + SW'(1);
            end else if (loop) begin
              state_nx = LOAD;
              step_nx  = '0;
            end else begin
              state_nx = IDLE;
              step_nx  = '0;
              done_set = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // A natural finish keeps the last mask through the first IDLE cycle; a stop blanks at once.
  always_comb begin
    busy   = (state != IDLE);
    led_nx = led_q;
    if (state == IDLE || !en)
      led_nx = '0;
    else if (state == LOAD && !start)
      led_nx = step_mask;
  end

  always_ff @(posedge sys_clock or negedge resetn) begin
    if (!resetn) begin
      led_q     <= '0;
      dur_cnt   <= '0;
      presc_cnt <= '0;
    end else begin
      led_q <= led_nx;
      if (state == LOAD) begin
        dur_cnt   <= clamp_dur(step_dur);
        presc_cnt <= '0;
      end else if (state == HOLD) begin
        if (tick) begin
          presc_cnt <= '0;
          dur_cnt   <= dur_cnt - 16'd1;
        end else begin
          presc_cnt <= presc_cnt + PRESC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus randomized one-shot
// tables compared cycle by cycle against an expected LED trace built from the step rules.
module tb_led_seq_ctrl;

  localparam int unsigned NL = 2;
  localparam int unsigned DP = 8;
  localparam int unsigned PW = 24;

  logic          sys_clock = 1'b0;
  logic          resetn    = 1'b0;
  logic [1:0]    htrans    = '0;
  logic          hready    = 1'b1;
  logic          hwrite    = 1'b0;
  logic [31:0]   haddr     = '0;
  logic [31:0]   hwdata    = '0;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic [NL-1:0] led;
  logic          irq;

  int unsigned   n_pass  = 0;
  int unsigned   n_total = 0;
  logic [31:0]   tbl [DP];
  logic [NL-1:0] exp_q [$];

  led_seq_ctrl #(.NUM_LEDS(NL), .DEPTH(DP), .PRESC_W(PW)) dut (
    .sys_clock         (sys_clock),
    .resetn            (resetn),
    .mem_ahb_htrans    (htrans),
    .mem_ahb_hready    (hready),
    .mem_ahb_hwrite    (hwrite),
    .mem_ahb_haddr     (haddr),
    .mem_ahb_hwdata    (hwdata),
    .mem_ahb_hreadyout (hreadyout),
    .mem_ahb_hresp     (hresp),
    .mem_ahb_hrdata    (hrdata),
    .led               (led),
    .irq               (irq)
  );

  always #5 sys_clock = ~sys_clock;

  // Returns 1ns after the edge that ends the data phase.
  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    htrans = 2'b10; hwrite = 1'b1; haddr = {24'h0, a};
    @(posedge sys_clock); #1;
    htrans = 2'b00; hwrite = 1'b0; hwdata = d;
    @(posedge sys_clock); #1;
    if (a >= 8'h40 && a < 8'h60) tbl[a[4:2]] = d;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    htrans = 2'b10; hwrite = 1'b0; haddr = {24'h0, a};
    @(posedge sys_clock); #1;
    htrans = 2'b00;
    d = hrdata;
    @(posedge sys_clock); #1;
  endtask

  // Expected LED value at each edge after the CTRL write returns: one edge of the
  // previous value, then each step's mask for DUR*(PRESC+1)+1 edges, then the tail.
  function automatic void build_trace(input logic [NL-1:0] first, input int unsigned presc,
                                      input int unsigned nst, input int unsigned reps,
                                      input int unsigned tail);
    int unsigned n;
    n = (nst == 0) ? 1 : ((nst > DP) ? DP : nst);
    exp_q.delete();
    exp_q.push_back(first);
    repeat (reps) begin
      for (int unsigned i = 0; i < n; i++) begin
        int unsigned d;
        d = 32'(tbl[i][31:16]);
        if (d == 0) d = 1;
        repeat (d * (presc + 1) + 1) exp_q.push_back(tbl[i][NL-1:0]);
      end
    end
    repeat (tail) exp_q.push_back('0);
  endfunction

  task automatic program_two_steps();
    ahb_write(8'h04, 32'd3);
    ahb_write(8'h08, 32'd2);
    ahb_write(8'h40, 32'h0002_0001);
    ahb_write(8'h44, 32'h0001_0002);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [7:0]  addrs [12];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h5C};
    n_total++;
    if (led !== 2'b00 || irq !== 1'b0) $display("FAIL reset_out: led=%b irq=%b want led=00 irq=0", led, irq); else n_pass++;
    n_total++;
    if (hreadyout !== 1'b1 || hresp !== 1'b0) $display("FAIL reset_ahb: hreadyout=%b hresp=%b want 1/0", hreadyout, hresp); else n_pass++;
    foreach (addrs[i]) begin
      ahb_read(addrs[i], rd);
      n_total++;
      if (rd !== 32'h0) $display("FAIL reset_reg %02h: got %08h want 00000000", addrs[i], rd); else n_pass++;
    end
  endtask

  task automatic test_regmap();
    logic [31:0] rd;
    logic [7:0]  wa [7];
    logic [31:0] wd [7];
    logic [7:0]  ra [8];
    logic [31:0] rw [8];
    wa = '{8'h10, 8'h60, 8'h04, 8'h08, 8'h00, 8'h4C, 8'h0C};
    wd = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    ra = '{8'h10, 8'h60, 8'h40, 8'h04, 8'h08, 8'h00, 8'h4C, 8'h0C};
    rw = '{32'h0, 32'h0, 32'h0, 32'h00FF_FFFF, 32'h1F, 32'h6, 32'hFFFF_0003, 32'h0};
    foreach (wa[i]) ahb_write(wa[i], wd[i]);
    foreach (ra[i]) begin
      ahb_read(ra[i], rd);
      n_total++;
      if (rd !== rw[i]) $display("FAIL regmap %02h: got %08h want %08h", ra[i], rd, rw[i]); else n_pass++;
    end
    ahb_write(8'h00, 32'h0);
    ahb_write(8'h04, 32'h0);
    ahb_write(8'h08, 32'h0);
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    program_two_steps();
    build_trace(2'b00, 3, 2, 1, 3);
    ahb_write(8'h00, 32'h5);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge sys_clock); #1;
      n_total++;
      if (led !== exp_q[k]) $display("FAIL oneshot_led cyc %0d: got %b want %b", k, led, exp_q[k]); else n_pass++;
    end
    ahb_read(8'h0C, rd);
    n_total++;
    if (rd !== 32'h2) $display("FAIL oneshot_status: got %08h want 00000002", rd); else n_pass++;
    n_total++;
    if (irq !== 1'b1) $display("FAIL oneshot_irq: got %b want 1", irq); else n_pass++;
    ahb_read(8'h00, rd);
    n_total++;
    if (rd !== 32'h4) $display("FAIL oneshot_ctrl: got %08h want 00000004", rd); else n_pass++;
    ahb_write(8'h0C, 32'h2);
    n_total++;
    if (irq !== 1'b0) $display("FAIL oneshot_irq_clear: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_restart();
    logic [31:0] rd;
    program_two_steps();
    ahb_write(8'h00, 32'h5);
    repeat (11) @(posedge sys_clock);
    #1;
    build_trace(2'b10, 3, 2, 1, 3);
    ahb_write(8'h00, 32'h5);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge sys_clock); #1;
      n_total++;
      if (led !== exp_q[k]) $display("FAIL restart_led cyc %0d: got %b want %b", k, led, exp_q[k]); else n_pass++;
    end
    ahb_read(8'h0C, rd);
    n_total++;
    if (rd !== 32'h2) $display("FAIL restart_status: got %08h want 00000002", rd); else n_pass++;
    ahb_write(8'h0C, 32'h2);
  endtask

  task automatic test_stop();
    logic [31:0] rd;
    program_two_steps();
    build_trace(2'b00, 3, 2, 1, 0);
    ahb_write(8'h00, 32'h5);
    for (int k = 0; k < 11; k++) begin
      @(posedge sys_clock); #1;
      n_total++;
      if (led !== exp_q[k]) $display("FAIL stop_led cyc %0d: got %b want %b", k, led, exp_q[k]); else n_pass++;
    end
    ahb_write(8'h00, 32'h0);
    n_total++;
    if (led !== 2'b10) $display("FAIL stop_before: got %b want 10", led); else n_pass++;
    @(posedge sys_clock); #1;
    n_total++;
    if (led !== 2'b00) $display("FAIL stop_led_off: got %b want 00", led); else n_pass++;
    ahb_read(8'h0C, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL stop_status: got %08h want 00000000", rd); else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL stop_irq: got %b want 0", irq); else n_pass++;
  endtask

  task automatic test_loop();
    logic [31:0] rd;
    program_two_steps();
    build_trace(2'b00, 3, 2, 3, 0);
    ahb_write(8'h00, 32'h3);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge sys_clock); #1;
      n_total++;
      if (led !== exp_q[k]) $display("FAIL loop_led cyc %0d: got %b want %b", k, led, exp_q[k]); else n_pass++;
    end
    ahb_read(8'h0C, rd);
    n_total++;
    if ((rd & 32'h3) !== 32'h1) $display("FAIL loop_status: got %08h want busy=1 done=0", rd); else n_pass++;
    ahb_write(8'h00, 32'h0);
    @(posedge sys_clock); #1;
    n_total++;
    if (led !== 2'b00) $display("FAIL loop_stop_led: got %b want 00", led); else n_pass++;
    ahb_read(8'h0C, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL loop_stop_status: got %08h want 00000000", rd); else n_pass++;
  endtask

  task automatic test_clamp();
    logic [31:0] rd;
    ahb_write(8'h04, 32'd0);
    ahb_write(8'h08, 32'd0);
    ahb_write(8'h40, 32'h0000_0001);
    build_trace(2'b00, 0, 0, 1, 3);
    ahb_write(8'h00, 32'h1);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge sys_clock); #1;
      n_total++;
      if (led !== exp_q[k]) $display("FAIL clamp_led cyc %0d: got %b want %b", k, led, exp_q[k]); else n_pass++;
    end
    ahb_read(8'h0C, rd);
    n_total++;
    if (rd !== 32'h2) $display("FAIL clamp_status: got %08h want 00000002", rd); else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL clamp_irq: got %b want 0", irq); else n_pass++;
    ahb_write(8'h0C, 32'h2);
  endtask

  task automatic test_random();
    logic [31:0] rd;
    repeat (6) begin
      int unsigned p;
      int unsigned n;
      logic        ie;
      p  = $urandom_range(0, 3);
      n  = $urandom_range(0, 10);
      ie = 1'($urandom);
      for (int unsigned i = 0; i < DP; i++)
        ahb_write(8'(8'h40 + 4 * i), {16'($urandom_range(0, 3)), 14'($urandom), 2'($urandom_range(0, 3))});
      ahb_write(8'h04, p);
      ahb_write(8'h08, n);
      build_trace(2'b00, p, n, 1, 3);
      ahb_write(8'h00, 32'({ie, 2'b01}));
      for (int k = 0; k < exp_q.size(); k++) begin
        @(posedge sys_clock); #1;
        n_total++;
        if (led !== exp_q[k]) $display("FAIL rand_led p=%0d n=%0d cyc %0d: got %b want %b", p, n, k, led, exp_q[k]); else n_pass++;
      end
      ahb_read(8'h0C, rd);
      n_total++;
      if (rd !== 32'h2) $display("FAIL rand_status: got %08h want 00000002", rd); else n_pass++;
      n_total++;
      if (irq !== ie) $display("FAIL rand_irq: got %b want %b", irq, ie); else n_pass++;
      ahb_write(8'h0C, 32'h2);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    ahb_write(8'h04, 32'd50);
    ahb_write(8'h08, 32'd1);
    ahb_write(8'h40, 32'h0005_0003);
    ahb_write(8'h00, 32'h5);
    repeat (20) @(posedge sys_clock);
    #1;
    n_total++;
    if (led !== 2'b11) $display("FAIL areset_before: got %b want 11", led); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_total++;
    if (led !== 2'b00 || irq !== 1'b0) $display("FAIL areset_out: led=%b irq=%b want 00/0", led, irq); else n_pass++;
    @(posedge sys_clock); #1;
    resetn = 1'b1;
    ahb_read(8'h0C, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL areset_status: got %08h want 00000000", rd); else n_pass++;
    ahb_read(8'h40, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL areset_step0: got %08h want 00000000", rd); else n_pass++;
    ahb_read(8'h04, rd);
    n_total++;
    if (rd !== 32'h0) $display("FAIL areset_presc: got %08h want 00000000", rd); else n_pass++;
    n_total++;
    if (led !== 2'b00) $display("FAIL areset_led_after: got %b want 00", led); else n_pass++;
  endtask

  initial begin
    foreach (tbl[i]) tbl[i] = '0;
    repeat (3) @(posedge sys_clock);
    #1 resetn = 1'b1;
    test_reset();
    test_regmap();
    test_oneshot();
    test_restart();
    test_stop();
    test_loop();
    test_clamp();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
